// File: rtl/ahb_lite_bus_fabric_pkg.sv
// rtl/ahb_lite_bus_fabric_pkg.sv - shared AHB-Lite bus encodings, error causes and fabric state codes
package ahb_lite_bus_fabric_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_UNMAPPED    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT     = 2'b10;
    localparam logic [1:0] CAUSE_QUARANTINED = 2'b11;

    localparam logic [1:0] ST_DP_IDLE  = 2'd0;
    localparam logic [1:0] ST_DP_SLAVE = 2'd1;
    localparam logic [1:0] ST_ERR1     = 2'd2;
    localparam logic [1:0] ST_ERR2     = 2'd3;

endpackage

// File: rtl/ahb_lite_bus_fabric_default_slave.sv
// rtl/ahb_lite_bus_fabric_default_slave.sv - two-cycle ERROR sequencer and fabric error capture
// Ports:
//   HCLK, HRESETn         clock, async active-low reset
//   err_start             request an ERROR data phase starting next cycle
//   err_addr_in/cause_in  address and cause to report for that error
//   err_state             ST_DP_IDLE when inactive, else ST_ERR1 / ST_ERR2
//   ERR_IRQ               one-cycle pulse in ERR2
//   ERR_ADDR/ERR_CAUSE    last captured error, updated on entry to ERR2
module ahb_lite_default_slave
    import ahb_lite_bus_fabric_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        err_start,
    input  logic [31:0] err_addr_in,
    input  logic [1:0]  err_cause_in,
    output logic [1:0]  err_state,
    output logic        ERR_IRQ,
    output logic [31:0] ERR_ADDR,
    output logic [1:0]  ERR_CAUSE
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [1:0]  pend_cause_q, pend_cause_d;
    logic        irq_q, irq_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  cause_q, cause_d;

    always_comb begin
        state_d = ST_DP_IDLE;
        if (err_start) begin
            state_d = ST_ERR1;
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end
        pend_addr_d  = err_start ? err_addr_in  : pend_addr_q;
        pend_cause_d = err_start ? err_cause_in : pend_cause_q;
        // Capture happens on the ERR1->ERR2 edge so a reset during ERR1 leaves no trace.
        irq_d   = (state_q == ST_ERR1);
        addr_d  = (state_q == ST_ERR1) ? pend_addr_q  : addr_q;
        cause_d = (state_q == ST_ERR1) ? pend_cause_q : cause_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_DP_IDLE;
            pend_addr_q  <= '0;
            pend_cause_q <= CAUSE_NONE;
            irq_q        <= 1'b0;
            addr_q       <= '0;
            cause_q      <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            pend_cause_q <= pend_cause_d;
            irq_q        <= irq_d;
            addr_q       <= addr_d;
            cause_q      <= cause_d;
        end
    end

    assign err_state = state_q;
    assign ERR_IRQ   = irq_q;
    assign ERR_ADDR  = addr_q;
    assign ERR_CAUSE = cause_q;

endmodule

// File: rtl/ahb_lite_bus_fabric.sv
// rtl/ahb_lite_bus_fabric.sv - AHB-Lite single-master decoder/mux with default slave, timeout and quarantine
// Ports:
//   HCLK, HRESETn              clock, async active-low reset
//   HADDR, HTRANS              master address phase
//   HREADY, HRESP, HRDATA      data-phase response to master (HREADY also to slaves)
//   HSEL_A                     combinational one-hot slave select
//   HREADYOUT_A, HRESP_A, HRDATA_A  per-slave responses, slave i data at [i*32+:32]
//   ERR_IRQ, ERR_ADDR, ERR_CAUSE    fabric-generated error report
//   QUARANTINE                 slaves disabled after a timeout
module ahb_lite_bus_fabric
    import ahb_lite_bus_fabric_pkg::*;
#(
    parameter int                         NUM_SLAVES     = 8,
    parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE       = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK       = {NUM_SLAVES{32'hFFFF_0000}},
    parameter int                         TIMEOUT_CYCLES = 256
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [31:0]                HADDR,
    input  logic [1:0]                 HTRANS,
    output logic                       HREADY,
    output logic                       HRESP,
    output logic [31:0]                HRDATA,
    output logic [NUM_SLAVES-1:0]      HSEL_A,
    input  logic [NUM_SLAVES-1:0]      HREADYOUT_A,
    input  logic [NUM_SLAVES-1:0]      HRESP_A,
    input  logic [NUM_SLAVES*32-1:0]   HRDATA_A,
    output logic                       ERR_IRQ,
    output logic [31:0]                ERR_ADDR,
    output logic [1:0]                 ERR_CAUSE,
    output logic [NUM_SLAVES-1:0]      QUARANTINE
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // Wide enough to hold TIMEOUT_CYCLES; with timeout disabled it just saturates.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [NUM_SLAVES-1:0] match_raw;
    logic [NUM_SLAVES-1:0] sel;
    logic [IW-1:0]         sel_idx;
    logic                  found;
    logic                  xfer_req;

    logic [1:0]            dp_state_q, dp_state_d;
    logic [IW-1:0]         tgt_q, tgt_d;
    logic [31:0]           addr_q, addr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] quar_q, quar_d;

    logic                  err_start;
    logic [31:0]           err_addr;
    logic [1:0]            err_cause;
    logic [1:0]            err_state;
    logic [1:0]            state;

    // Decode: raw match ignores quarantine so a quarantined-only hit can be told apart from unmapped.
    always_comb begin
        match_raw = '0;
        sel       = '0;
        sel_idx   = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match_raw[i] = ((HADDR & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]);
            if (match_raw[i] && !quar_q[i] && !found) begin
                found   = 1'b1;
                sel[i]  = 1'b1;
                sel_idx = IW'(i);
            end
        end
    end

    assign HSEL_A   = sel;
    assign xfer_req = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

    // The error sequencer overrides the data-phase state while it is active.
    always_comb begin
        state  = (err_state != ST_DP_IDLE) ? err_state : dp_state_q;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = '0;
        case (state)
            ST_DP_SLAVE: begin
                HREADY = HREADYOUT_A[tgt_q];
                HRESP  = HRESP_A[tgt_q];
                HRDATA = HRDATA_A[32*tgt_q +: 32];
            end
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = HRESP_ERROR;
            end
            ST_ERR2: begin
                HRESP  = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    always_comb begin
        dp_state_d = dp_state_q;
        tgt_d      = tgt_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        quar_d     = quar_q;
        err_start  = 1'b0;
        err_addr   = addr_q;
        err_cause  = CAUSE_TIMEOUT;
        if (HREADY) begin
            cnt_d      = '0;
            addr_d     = HADDR;
            tgt_d      = sel_idx;
            dp_state_d = ST_DP_IDLE;
            if (xfer_req) begin
                if (found) begin
                    dp_state_d = ST_DP_SLAVE;
                end else begin
                    err_start = 1'b1;
                    err_addr  = HADDR;
                    err_cause = (|match_raw) ? CAUSE_QUARANTINED : CAUSE_UNMAPPED;
                end
            end
        end else if (state == ST_DP_SLAVE) begin
            // Only reached with the slave stalling, so a same-cycle ready never times out.
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                err_start     = 1'b1;
                quar_d[tgt_q] = 1'b1;
                dp_state_d    = ST_DP_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_state_q <= ST_DP_IDLE;
            tgt_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            quar_q     <= '0;
        end else begin
            dp_state_q <= dp_state_d;
            tgt_q      <= tgt_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            quar_q     <= quar_d;
        end
    end

    assign QUARANTINE = quar_q;

    ahb_lite_default_slave u_default_slave (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .err_start    (err_start),
        .err_addr_in  (err_addr),
        .err_cause_in (err_cause),
        .err_state    (err_state),
        .ERR_IRQ      (ERR_IRQ),
        .ERR_ADDR     (ERR_ADDR),
        .ERR_CAUSE    (ERR_CAUSE)
    );

endmodule
